// File: rtl/rd_addr_sequencer.sv
// Register-number / bit-index read address sequencer for the IIC slave read path.
// Optional feature: define RD_AUTOINC_EN to auto-increment regnum (with wrap) after each master ACK.
module rd_addr_sequencer #(
  parameter int REG_NUM = 16
) (
  input  logic       SYS_CLK,
  input  logic       SYS_NRST,
  input  logic       rd_start_i,
  input  logic [3:0] start_regnum_i,
  input  logic       bit_adv_i,
  input  logic       ack_valid_i,
  input  logic       ack_i,
  input  logic       rd_stop_i,
  output logic       raddr_rst_o,
  output logic [3:0] ctrl_regnum_sel_o,
  output logic [2:0] ctrl_regbit_sel_o,
  output logic       busy_o,
  output logic       byte_done_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK_WAIT} state_t;

  localparam logic [4:0] REG_LIMIT = 5'(REG_NUM);

  state_t     state;
  logic [3:0] start_reg;
  logic [3:0] next_regnum;

  // Out-of-range start registers fall back to register 0.
  always_comb begin
    start_reg = start_regnum_i;
    if ({1'b0, start_regnum_i} >= REG_LIMIT) start_reg = 4'd0;
  end

`ifdef RD_AUTOINC_EN
  localparam logic [3:0] LAST_REG = 4'(REG_NUM - 1);

  always_comb begin
    next_regnum = ctrl_regnum_sel_o + 4'd1;
    if (ctrl_regnum_sel_o == LAST_REG) next_regnum = 4'd0;
  end
`else
  always_comb begin
    next_regnum = ctrl_regnum_sel_o;
  end
`endif

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state             <= IDLE;
      raddr_rst_o       <= 1'b1;
      ctrl_regnum_sel_o <= 4'd0;
      ctrl_regbit_sel_o <= 3'd7;
      busy_o            <= 1'b0;
      byte_done_o       <= 1'b0;
    end else begin
      byte_done_o <= 1'b0;
      if (rd_stop_i) begin
        state             <= IDLE;
        raddr_rst_o       <= 1'b1;
        ctrl_regbit_sel_o <= 3'd7;
        busy_o            <= 1'b0;
      end else if (rd_start_i) begin
        state             <= SHIFT;
        raddr_rst_o       <= 1'b0;
        ctrl_regnum_sel_o <= start_reg;
        ctrl_regbit_sel_o <= 3'd7;
        busy_o            <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            if (bit_adv_i) begin
              if (ctrl_regbit_sel_o != 3'd0) begin
                ctrl_regbit_sel_o <= ctrl_regbit_sel_o - 3'd1;
              end else begin
                state       <= ACK_WAIT;
                byte_done_o <= 1'b1;
              end
            end
          end
          // Bit advances are ignored here; only the master's ACK slot moves us on.
          ACK_WAIT: begin
            if (ack_valid_i) begin
              ctrl_regbit_sel_o <= 3'd7;
              if (ack_i) begin
                state             <= SHIFT;
                ctrl_regnum_sel_o <= next_regnum;
              end else begin
                state       <= IDLE;
                raddr_rst_o <= 1'b1;
                busy_o      <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rd_addr_sequencer.sv
// Self-checking bench for rd_addr_sequencer: two instances (REG_NUM 16 and 10) share stimulus
// and are checked against a behavioural model of the read burst.
module tb_rd_addr_sequencer;

  logic       SYS_CLK;
  logic       SYS_NRST;
  logic       rd_start_i;
  logic [3:0] start_regnum_i;
  logic       bit_adv_i;
  logic       ack_valid_i;
  logic       ack_i;
  logic       rd_stop_i;

  logic       a_raddr_rst, a_busy, a_done, b_raddr_rst, b_busy, b_done;
  logic [3:0] a_regnum, b_regnum;
  logic [2:0] a_regbit, b_regbit;

  int n_tests = 0;
  int n_fail  = 0;

  rd_addr_sequencer #(.REG_NUM(16)) dut_a (
    .SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST), .rd_start_i(rd_start_i),
    .start_regnum_i(start_regnum_i), .bit_adv_i(bit_adv_i), .ack_valid_i(ack_valid_i),
    .ack_i(ack_i), .rd_stop_i(rd_stop_i), .raddr_rst_o(a_raddr_rst),
    .ctrl_regnum_sel_o(a_regnum), .ctrl_regbit_sel_o(a_regbit), .busy_o(a_busy),
    .byte_done_o(a_done)
  );

  rd_addr_sequencer #(.REG_NUM(10)) dut_b (
    .SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST), .rd_start_i(rd_start_i),
    .start_regnum_i(start_regnum_i), .bit_adv_i(bit_adv_i), .ack_valid_i(ack_valid_i),
    .ack_i(ack_i), .rd_stop_i(rd_stop_i), .raddr_rst_o(b_raddr_rst),
    .ctrl_regnum_sel_o(b_regnum), .ctrl_regbit_sel_o(b_regbit), .busy_o(b_busy),
    .byte_done_o(b_done)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  // Model: a burst is "active" while reading; bits_left counts unread bits of the byte (0 = awaiting ACK).
  int m_regn  [2] = '{16, 10};
  bit m_active[2];
  int m_left  [2];
  int m_reg   [2];
  bit m_done  [2];

  function automatic logic [9:0] exp_vec(int i);
    int rb;
    rb = !m_active[i] ? 7 : (m_left[i] == 0 ? 0 : m_left[i] - 1);
    return {~m_active[i], m_active[i], m_done[i], 4'(m_reg[i]), 3'(rb)};
  endfunction

  function automatic logic [9:0] obs(int i);
    if (i == 0) return {a_raddr_rst, a_busy, a_done, a_regnum, a_regbit};
    return {b_raddr_rst, b_busy, b_done, b_regnum, b_regbit};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0; m_left[i] = 8; m_reg[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit stop, input bit start, input int sr,
                            input bit adv, input bit av, input bit ack);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (stop) begin
        m_active[i] = 1'b0; m_left[i] = 8;
      end else if (start) begin
        m_active[i] = 1'b1; m_left[i] = 8;
        m_reg[i] = (sr < m_regn[i]) ? sr : 0;
      end else if (m_active[i] && m_left[i] == 0 && av) begin
        m_left[i] = 8;
        if (ack) begin
`ifdef RD_AUTOINC_EN
          m_reg[i] = (m_reg[i] + 1) % m_regn[i];
`endif
        end else begin
          m_active[i] = 1'b0;
        end
      end else if (m_active[i] && m_left[i] > 0 && adv) begin
        m_left[i]--;
        if (m_left[i] == 0) m_done[i] = 1'b1;
      end
    end
  endtask

  // Drives one cycle of pulses starting at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input bit stop, input bit start, input logic [3:0] sr,
                               input bit adv, input bit av, input bit ack);
    rd_stop_i = stop; rd_start_i = start; start_regnum_i = sr;
    bit_adv_i = adv; ack_valid_i = av; ack_i = ack;
    @(posedge SYS_CLK);
    model_step(stop, start, int'(sr), adv, av, ack);
    @(negedge SYS_CLK);
    rd_stop_i = 0; rd_start_i = 0; bit_adv_i = 0; ack_valid_i = 0; ack_i = 0;
  endtask

  task automatic test_reset();
    applyStimulus(0, 1, 4'd9, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 4'd0, 1, 0, 0);
    n_tests++;
    if (a_regbit !== 3'd3) begin
      n_fail++; $display("[TB] FAIL reset_pre regbit got=%0d exp=3", a_regbit);
    end
    #2 SYS_NRST = 1'b0;
    #1 model_reset();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== exp_vec(i)) begin
        n_fail++; $display("[TB] FAIL reset_async inst%0d got=%b exp=%b", i, obs(i), exp_vec(i));
      end
    end
    @(negedge SYS_CLK);
    n_tests++;
    if (obs(0) !== 10'b1_0_0_0000_111) begin
      n_fail++; $display("[TB] FAIL reset_state got=%b exp=%b", obs(0), 10'b1_0_0_0000_111);
    end
    SYS_NRST = 1'b1;
    @(negedge SYS_CLK);
  endtask

  task automatic test_byte_walk();
    applyStimulus(0, 1, 4'd5, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 4'd0, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (obs(i) !== exp_vec(i)) begin
          n_fail++; $display("[TB] FAIL byte_walk step%0d inst%0d got=%b exp=%b", k, i, obs(i), exp_vec(i));
        end
      end
    end
    n_tests++;
    if (a_done !== 1'b1 || a_regbit !== 3'd0 || a_busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL byte_done got=%b/%0d/%b exp=1/0/1", a_done, a_regbit, a_busy);
    end
    applyStimulus(0, 0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== exp_vec(i)) begin
        n_fail++; $display("[TB] FAIL ack_wait_adv inst%0d got=%b exp=%b", i, obs(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_ack_wrap();
    applyStimulus(0, 1, 4'd15, 0, 0, 0);
    repeat (8) applyStimulus(0, 0, 4'd0, 1, 0, 0);
    applyStimulus(0, 0, 4'd0, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== exp_vec(i)) begin
        n_fail++; $display("[TB] FAIL ack_wrap inst%0d got=%b exp=%b", i, obs(i), exp_vec(i));
      end
    end
`ifdef RD_AUTOINC_EN
    n_tests++;
    if (a_regnum !== 4'd0) begin
      n_fail++; $display("[TB] FAIL ack_wrap_regnum got=%0d exp=0", a_regnum);
    end
`else
    n_tests++;
    if (a_regnum !== 4'd15) begin
      n_fail++; $display("[TB] FAIL ack_hold_regnum got=%0d exp=15", a_regnum);
    end
`endif
  endtask

  task automatic test_nack();
    applyStimulus(0, 1, 4'd3, 0, 0, 0);
    repeat (8) applyStimulus(0, 0, 4'd0, 1, 0, 0);
    applyStimulus(0, 0, 4'd0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== exp_vec(i)) begin
        n_fail++; $display("[TB] FAIL nack inst%0d got=%b exp=%b", i, obs(i), exp_vec(i));
      end
    end
    n_tests++;
    if (a_raddr_rst !== 1'b1 || a_busy !== 1'b0 || a_regnum !== 4'd3) begin
      n_fail++; $display("[TB] FAIL nack_idle got=%b/%b/%0d exp=1/0/3", a_raddr_rst, a_busy, a_regnum);
    end
  endtask

  task automatic test_stop_start();
    applyStimulus(0, 1, 4'd7, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 4'd0, 1, 0, 0);
    applyStimulus(1, 1, 4'd2, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== exp_vec(i)) begin
        n_fail++; $display("[TB] FAIL stop_wins inst%0d got=%b exp=%b", i, obs(i), exp_vec(i));
      end
    end
    applyStimulus(0, 1, 4'd4, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 4'd0, 1, 0, 0);
    applyStimulus(0, 1, 4'd6, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== exp_vec(i)) begin
        n_fail++; $display("[TB] FAIL restart inst%0d got=%b exp=%b", i, obs(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_clamp();
    applyStimulus(0, 1, 4'd12, 0, 0, 0);
    n_tests++;
    if (b_regnum !== 4'd0 || a_regnum !== 4'd12) begin
      n_fail++; $display("[TB] FAIL clamp got=%0d/%0d exp=12/0", a_regnum, b_regnum);
    end
  endtask

  task automatic test_random();
    bit stop, start, adv, av, ack;
    int k;
    for (int c = 0; c < 600; c++) begin
      stop  = ($urandom_range(0, 99) < 3);
      start = ($urandom_range(0, 99) < 5);
      k     = $urandom_range(0, 99);
      adv   = (k < 60);
      av    = (k >= 60 && k < 80);
      ack   = ($urandom_range(0, 3) != 0);
      applyStimulus(stop, start, 4'($urandom_range(0, 15)), adv, av, ack);
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (obs(i) !== exp_vec(i)) begin
          n_fail++; $display("[TB] FAIL random cyc%0d inst%0d got=%b exp=%b", c, i, obs(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    SYS_NRST = 1'b0;
    rd_stop_i = 0; rd_start_i = 0; start_regnum_i = 0;
    bit_adv_i = 0; ack_valid_i = 0; ack_i = 0;
    model_reset();
    repeat (3) @(negedge SYS_CLK);
    SYS_NRST = 1'b1;
    @(negedge SYS_CLK);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== exp_vec(i)) begin
        n_fail++; $display("[TB] FAIL initial inst%0d got=%b exp=%b", i, obs(i), exp_vec(i));
      end
    end
    test_reset();
    test_byte_walk();
    test_ack_wrap();
    test_nack();
    test_stop_start();
    test_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
